// File: rtl/lsu_dccm_stbuf.sv
// Store buffer between the LSU commit stage and the DCCM write port.
// Committed stores queue up in a small circular FIFO and drain to the
// DCCM on any cycle where loads and freeze leave the port free. A store
// that hits the word held in the youngest entry merges into it, so that
// partial-word writes to one word share a single DCCM write.
// Loads get per-byte forwarding from every entry still held, including
// the one draining this cycle.
module lsu_dccm_stbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  input  logic [DATA_W/8-1:0]    st_byteen,
  output logic                   st_ready,
  input  logic                   ld_rden,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic                   lsu_freeze,
  output logic [DATA_W/8-1:0]    fwd_hit,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   dccm_wren,
  output logic [ADDR_W-1:0]      dccm_wr_addr,
  output logic [DATA_W-1:0]      dccm_wr_data,
  output logic [DATA_W/8-1:0]    dccm_wr_byteen,
  output logic                   stbuf_empty
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int WA = ADDR_W - LW;

  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WA-1:0]     ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [NB-1:0]     ent_mask [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_m1;
  logic [PW:0]   count;

  logic [WA-1:0]     st_word;
  logic [WA-1:0]     ld_word;
  logic              drain;
  logic              accept;
  logic              coalesce;
  logic              alloc;
  logic [DATA_W-1:0] st_lane_data;
  logic [DATA_W-1:0] coal_data;
  logic [PW-1:0]     fwd_idx;
  logic              unused_addr_lsb;

  assign st_word = st_addr[ADDR_W-1:LW];
  assign ld_word = ld_addr[ADDR_W-1:LW];
  assign tail_m1 = tail - PTR_ONE;

  // Byte offset bits carry no information for word-granular entries.
  assign unused_addr_lsb = ^{st_addr[LW-1:0], ld_addr[LW-1:0]};

  assign st_ready    = (count != CNT_FULL);
  assign stbuf_empty = (count == '0);

  assign drain  = (count != '0) & ~ld_rden & ~lsu_freeze;
  assign accept = st_valid & st_ready;

  // The youngest entry is the head only when count==1; if it is leaving
  // this cycle the store must take a fresh slot instead of merging.
  assign coalesce = accept & (count != '0) & (ent_addr[tail_m1] == st_word)
                  & ~(drain & (tail_m1 == head));
  assign alloc    = accept & ~coalesce;

  // Lane-masked store data for a new entry, and merged data for coalescing.
  always_comb begin
    st_lane_data = '0;
    coal_data    = ent_data[tail_m1];
    for (int b = 0; b < NB; b++) begin
      if (st_byteen[b]) begin
        st_lane_data[8*b +: 8] = st_data[8*b +: 8];
        coal_data[8*b +: 8]    = st_data[8*b +: 8];
      end
    end
  end

  // FIFO pointers, occupancy and entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_mask[i] <= '0;
      end
    end else begin
      if (drain) begin
        head           <= head + PTR_ONE;
        ent_mask[head] <= '0;
      end
      if (coalesce) begin
        ent_data[tail_m1] <= coal_data;
        ent_mask[tail_m1] <= ent_mask[tail_m1] | st_byteen;
      end
      if (alloc) begin
        ent_addr[tail] <= st_word;
        ent_data[tail] <= st_lane_data;
        ent_mask[tail] <= st_byteen;
        tail           <= tail + PTR_ONE;
      end
      case ({alloc, drain})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // DCCM write port presents the head entry whenever it drains.
  always_comb begin
    dccm_wren      = 1'b0;
    dccm_wr_addr   = '0;
    dccm_wr_data   = '0;
    dccm_wr_byteen = '0;
    if (drain) begin
      dccm_wren      = 1'b1;
      dccm_wr_addr   = {ent_addr[head], {LW{1'b0}}};
      dccm_wr_data   = ent_data[head];
      dccm_wr_byteen = ent_mask[head];
    end
  end

  // Forwarding walks oldest to youngest so the youngest valid lane wins.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (ent_addr[fwd_idx] == ld_word)) begin
        for (int b = 0; b < NB; b++) begin
          if (ent_mask[fwd_idx][b]) begin
            fwd_hit[b]          = 1'b1;
            fwd_data[8*b +: 8]  = ent_data[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_dccm_stbuf.sv
// Bench for lsu_dccm_stbuf: directed scenarios with a scoreboard of
// expected DCCM writes, checked in order by a write monitor.
module tb_lsu_dccm_stbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_byteen;
  logic        st_ready;
  logic        ld_rden;
  logic [15:0] ld_addr;
  logic        lsu_freeze;
  logic [3:0]  fwd_hit;
  logic [31:0] fwd_data;
  logic        dccm_wren;
  logic [15:0] dccm_wr_addr;
  logic [31:0] dccm_wr_data;
  logic [3:0]  dccm_wr_byteen;
  logic        stbuf_empty;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  lsu_dccm_stbuf #(.DEPTH(4), .ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_byteen(st_byteen), .st_ready(st_ready),
    .ld_rden(ld_rden), .ld_addr(ld_addr), .lsu_freeze(lsu_freeze),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .dccm_wren(dccm_wren), .dccm_wr_addr(dccm_wr_addr),
    .dccm_wr_data(dccm_wr_data), .dccm_wr_byteen(dccm_wr_byteen),
    .stbuf_empty(stbuf_empty)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_byteen = be;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.be   = be;
    sb_q.push_back(w);
  endtask

  // Bounded wait for all expected writes to appear and the buffer to empty.
  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || !stbuf_empty) && n < 20) begin
      tick();
      n++;
    end
    @(negedge clk);
    check_val({tag, "_sb_left"}, sb_q.size(), 0);
    check_val({tag, "_empty"}, stbuf_empty, 1);
    tick();
  endtask

  // Every DCCM write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dccm_wren) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_wr", {dccm_wr_addr, dccm_wr_byteen}, 0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check_val("wr_addr", dccm_wr_addr, e.addr);
        check_val("wr_data", dccm_wr_data, e.data);
        check_val("wr_be", dccm_wr_byteen, e.be);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ld_rden = 1'b0; lsu_freeze = 1'b0; ld_addr = 16'h0010;
    drive_st(16'h0010, 32'h12345678, 4'hF);   // must be dropped by reset
    tick(); tick();
    rst = 1'b0; st_valid = 1'b0;
    @(negedge clk);
    check_val("rst_ready", st_ready, 1);
    check_val("rst_empty", stbuf_empty, 1);
    check_val("rst_wren", dccm_wren, 0);
    check_val("rst_fwd_hit", fwd_hit, 0);
    check_val("rst_fwd_data", fwd_data, 0);
    tick();

    // Single store drains the following cycle.
    drive_st(16'h0010, 32'hAABBCCDD, 4'hF);
    expect_wr(16'h0010, 32'hAABBCCDD, 4'hF);
    @(negedge clk);
    check_val("s1_no_early_wr", dccm_wren, 0);
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    check_val("s1_wren", dccm_wren, 1);
    check_val("s1_not_empty", stbuf_empty, 0);
    tick();
    @(negedge clk);
    check_val("s1_empty", stbuf_empty, 1);
    check_val("s1_sb", sb_q.size(), 0);
    tick();

    // Two halves of one word merge into a single entry.
    ld_rden = 1'b1;
    drive_st(16'h0020, 32'h00001122, 4'h3); tick();
    drive_st(16'h0022, 32'h33440000, 4'hC); tick();
    st_valid = 1'b0;
    ld_addr  = 16'h0020;
    @(negedge clk);
    check_val("coal_count", dut.count, 1);
    check_val("coal_fwd_hit", fwd_hit, 4'hF);
    check_val("coal_fwd_data", fwd_data, 32'h33441122);
    check_val("coal_wren_blocked", dccm_wren, 0);
    expect_wr(16'h0020, 32'h33441122, 4'hF);
    tick();
    ld_rden = 1'b0;
    wait_drain("coal");

    // Fill to capacity; an extra store while full is ignored.
    ld_rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_st(16'h0100 + 16'(4*i), 32'hC0DE0000 + 32'(i), 4'hF);
      expect_wr(16'h0100 + 16'(4*i), 32'hC0DE0000 + 32'(i), 4'hF);
      tick();
    end
    st_valid = 1'b0;
    @(negedge clk);
    check_val("full_ready", st_ready, 0);
    check_val("full_count", dut.count, 4);
    tick();
    drive_st(16'h0200, 32'hBAD0BAD0, 4'hF);
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    check_val("full_ignored_count", dut.count, 4);
    check_val("full_ignored_ready", st_ready, 0);
    tick();
    ld_rden = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("full_back2back", dccm_wren, 1);
      tick();
    end
    @(negedge clk);
    check_val("full_drained", stbuf_empty, 1);
    check_val("full_sb", sb_q.size(), 0);
    tick();

    // Youngest matching entry wins forwarding; non-adjacent stores not merged.
    ld_rden = 1'b1;
    drive_st(16'h0040, 32'h000000AA, 4'h1); tick();
    drive_st(16'h0044, 32'h11111111, 4'hF); tick();
    drive_st(16'h0040, 32'h000000BB, 4'h1); tick();
    st_valid = 1'b0;
    ld_addr  = 16'h0040;
    @(negedge clk);
    check_val("fwd_count", dut.count, 3);
    check_val("fwd_hit_40", fwd_hit, 4'h1);
    check_val("fwd_data_40", fwd_data, 32'h000000BB);
    ld_addr = 16'h0044;
    #1;
    check_val("fwd_hit_44", fwd_hit, 4'hF);
    check_val("fwd_data_44", fwd_data, 32'h11111111);
    ld_addr = 16'h0048;
    #1;
    check_val("fwd_miss", fwd_hit, 4'h0);
    expect_wr(16'h0040, 32'h000000AA, 4'h1);
    expect_wr(16'h0044, 32'h11111111, 4'hF);
    expect_wr(16'h0040, 32'h000000BB, 4'h1);
    tick();
    ld_rden = 1'b0;
    wait_drain("fwd");

    // Store to the single departing entry allocates anew; forwarding still
    // sees the departing entry but not the incoming store.
    drive_st(16'h0080, 32'hDEADBEEF, 4'hF);
    expect_wr(16'h0080, 32'hDEADBEEF, 4'hF);
    tick();
    drive_st(16'h0080, 32'h00000055, 4'h1);
    expect_wr(16'h0080, 32'h00000055, 4'h1);
    ld_addr = 16'h0080;
    @(negedge clk);
    check_val("depart_fwd_data", fwd_data, 32'hDEADBEEF);
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    check_val("depart_count", dut.count, 1);
    tick();
    wait_drain("depart");

    // Reset while frozen with three entries discards them.
    lsu_freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_st(16'h0300 + 16'(4*i), 32'h5A5A0000 + 32'(i), 4'hF);
      tick();
    end
    st_valid = 1'b0;
    @(negedge clk);
    check_val("frz_count", dut.count, 3);
    check_val("frz_wren", dccm_wren, 0);
    tick();
    rst = 1'b1;
    drive_st(16'h030C, 32'h77777777, 4'hF);
    tick();
    rst = 1'b0;
    st_valid = 1'b0;
    @(negedge clk);
    check_val("frz_rst_count", dut.count, 0);
    check_val("frz_rst_ready", st_ready, 1);
    check_val("frz_rst_empty", stbuf_empty, 1);
    tick();
    lsu_freeze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("frz_no_wr", dccm_wren, 0);
      tick();
    end

    check_val("final_sb", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
